// File: rtl/axis_rti_bin_framer.sv
// Keeps the first 2^cfg_bins bins of each FFT frame, tags them in tuser with
// {dir, seq, bin} and closes every frame with tlast on its last kept bin.
module axis_rti_bin_framer #(
    parameter int CORDIC_WIDTH = 32,
    parameter int TUSER_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [3:0]              cfg_bins,
    input  logic                    cfg_dual,
    input  logic                    cfg_clr,
    input  logic [CORDIC_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [CORDIC_WIDTH-1:0] m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    sts_short,
    output logic [15:0]             sts_frames
);

    localparam int SEQ_W = TUSER_WIDTH - ADDR_WIDTH - 1;
    localparam int KW    = 17;
    localparam logic [3:0] BINS_MAX = 4'(ADDR_WIDTH);

    logic [15:0]      bin;
    logic             in_frame;
    logic [KW-1:0]    keep_q;
    logic             dir;
    logic [SEQ_W-1:0] seq;

    logic [3:0]    bins_clamped;
    logic [KW-1:0] keep_eff;
    logic [KW-1:0] bin_ext;
    logic          discard_next;
    logic          accept;
    logic          kept;
    logic          load;
    logic          drain;
    logic          end_bin;
    logic          short_end;

    // The frame-start beat sees the live cfg_bins; later beats use the latched keep.
    assign bins_clamped = (cfg_bins > BINS_MAX) ? BINS_MAX : cfg_bins;
    assign keep_eff     = in_frame ? keep_q : (KW'(1) << bins_clamped);
    assign bin_ext      = {1'b0, bin};

    assign discard_next  = in_frame && (bin_ext >= keep_q);
    assign s_axis_tready = discard_next | ~m_axis_tvalid | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign kept          = bin_ext < keep_eff;
    assign load          = accept & kept;
    assign drain         = m_axis_tvalid & m_axis_tready;
    assign end_bin       = bin_ext == (keep_eff - KW'(1));
    assign short_end     = bin_ext < (keep_eff - KW'(1));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tuser  <= {dir, seq, bin[ADDR_WIDTH-1:0]};
            m_axis_tlast  <= end_bin | s_axis_tlast;
        end else if (drain) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bin      <= '0;
            in_frame <= 1'b0;
            keep_q   <= KW'(1);
            dir      <= 1'b0;
            seq      <= '0;
        end else if (accept) begin
            if (!in_frame) begin
                keep_q <= keep_eff;
            end
            if (s_axis_tlast) begin
                bin      <= '0;
                in_frame <= 1'b0;
                seq      <= seq + SEQ_W'(1);
                dir      <= cfg_dual & ~dir;
            end else begin
                bin      <= (bin == 16'hFFFF) ? bin : bin + 16'd1;
                in_frame <= 1'b1;
            end
        end
    end

    // A clear coinciding with a frame end counts that frame but leaves sts_short low.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sts_short  <= 1'b0;
            sts_frames <= '0;
        end else if (cfg_clr) begin
            sts_short  <= 1'b0;
            sts_frames <= (accept & s_axis_tlast) ? 16'd1 : 16'd0;
        end else if (accept & s_axis_tlast) begin
            sts_frames <= sts_frames + 16'd1;
            if (short_end) begin
                sts_short <= 1'b1;
            end
        end
    end

endmodule
